// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive path.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux_1x4_decoder.sv
// Slot index to one-hot write enable; mirror of the transmit mux select tree.
module decoder_2x4
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0]    slot,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] we
);

  // One-hot decode of the slot, gated by the beat-accept qualifier.
  always_comb begin
    we = 4'b0000;
    if (en) begin
      case (slot)
        2'd0:    we = 4'b0001;
        2'd1:    we = 4'b0010;
        2'd2:    we = 4'b0100;
        2'd3:    we = 4'b1000;
        default: we = 4'b0000;
      endcase
    end else begin
      we = 4'b0000;
    end
  end

endmodule : decoder_2x4

// File: rtl/tdm_demux_1x4.sv
// Receive side of the 4-channel TDM link: slot tracking, frame rebuild,
// misalignment detection.
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int W        = 8,
  parameter bit REQ_SYNC = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         frame_valid,
  output logic         sync_err,
  output logic         locked
);

  state_e              state_r;
  logic [SLOT_W-1:0]   slot_r;
  logic [W-1:0]        stage_r [0:NUM_SLOTS-2];
  logic [W-1:0]        ch_r    [0:NUM_SLOTS-1];
  logic                frame_valid_r;
  logic                sync_err_r;
  logic                locked_r;

  state_e              next_state_s;
  logic [SLOT_W-1:0]   next_slot_s;
  logic [SLOT_W-1:0]   wr_slot_s;
  logic                accept_s;
  logic                err_s;
  logic                clear_s;
  logic [NUM_SLOTS-1:0] we_s;

  // Beat classification: where the beat goes, next slot/state, error flag.
  always_comb begin
    next_state_s = state_r;
    next_slot_s  = slot_r;
    wr_slot_s    = slot_r;
    accept_s     = 1'b0;
    err_s        = 1'b0;
    clear_s      = 1'b0;
    if (din_valid) begin
      case (state_r)
        HUNT: begin
          if (frame_sync) begin
            accept_s     = 1'b1;
            wr_slot_s    = 2'd0;
            next_slot_s  = 2'd1;
            next_state_s = LOCKED;
          end else begin
            next_slot_s  = 2'd0;
          end
        end
        LOCKED: begin
          if (frame_sync && (slot_r != 2'd0)) begin
            // Early sync restarts the frame with this beat as slot 0.
            err_s       = 1'b1;
            clear_s     = 1'b1;
            accept_s    = 1'b1;
            wr_slot_s   = 2'd0;
            next_slot_s = 2'd1;
          end else if (!frame_sync && (slot_r == 2'd0) && REQ_SYNC) begin
            err_s        = 1'b1;
            next_slot_s  = 2'd0;
            next_state_s = HUNT;
          end else begin
            accept_s    = 1'b1;
            wr_slot_s   = slot_r;
            next_slot_s = slot_r + 2'd1;
          end
        end
        default: begin
          next_state_s = HUNT;
          next_slot_s  = 2'd0;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  decoder_2x4 u_dec (
    .slot (wr_slot_s),
    .en   (accept_s),
    .we   (we_s)
  );

  // FSM, slot counter, staging and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= HUNT;
      slot_r        <= 2'd0;
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      locked_r      <= 1'b0;
      for (int i = 0; i < NUM_SLOTS - 1; i++) stage_r[i] <= '0;
      for (int i = 0; i < NUM_SLOTS; i++)     ch_r[i]    <= '0;
    end else begin
      state_r       <= next_state_s;
      slot_r        <= next_slot_s;
      locked_r      <= (next_state_s == LOCKED);
      frame_valid_r <= we_s[3];
      sync_err_r    <= err_s;
      if (clear_s) begin
        stage_r[1] <= '0;
        stage_r[2] <= '0;
      end
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if (we_s[i]) stage_r[i] <= din;
      end
      if (we_s[3]) begin
        ch_r[0] <= stage_r[0];
        ch_r[1] <= stage_r[1];
        ch_r[2] <= stage_r[2];
        ch_r[3] <= din;
      end
    end
  end

  assign ch0         = ch_r[0];
  assign ch1         = ch_r[1];
  assign ch2         = ch_r[2];
  assign ch3         = ch_r[3];
  assign frame_valid = frame_valid_r;
  assign sync_err    = sync_err_r;
  assign locked      = locked_r;

endmodule : tdm_demux_1x4
